// File: rtl/sys_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and fixed operand addresses for sys_ctrl_cmd.
package sys_ctrl_pkg;

  localparam int unsigned CMD_WIDTH = 8;

  localparam logic [CMD_WIDTH-1:0] CMD_RF_WR   = 8'hAA;
  localparam logic [CMD_WIDTH-1:0] CMD_RF_RD   = 8'hBB;
  localparam logic [CMD_WIDTH-1:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [CMD_WIDTH-1:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    TX_RD    = 4'd5,
    ALU_A    = 4'd6,
    ALU_B    = 4'd7,
    ALU_F    = 4'd8,
    ALU_WAIT = 4'd9,
    TX_LSB   = 4'd10,
    TX_MSB   = 4'd11
  } state_t;

endpackage

// File: rtl/sys_ctrl_cmd.sv
// Command decoder/sequencer: turns RX byte frames into register-file, ALU and TX FIFO traffic.
module sys_ctrl_cmd
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned ALU_OUT_WIDTH = 16,
  parameter int unsigned FUN_WIDTH     = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]    RF_RdData,
  input  logic                     RF_RdData_Valid,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VLD,
  input  logic                     FIFO_FULL,
  output logic                     RF_WrEn,
  output logic                     RF_RdEn,
  output logic [ADDR_WIDTH-1:0]    RF_Address,
  output logic [DATA_WIDTH-1:0]    RF_WrData,
  output logic                     ALU_EN,
  output logic [FUN_WIDTH-1:0]     ALU_FUN,
  output logic                     CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD
);

  state_t                   r_state;
  state_t                   w_next_state;

  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [ALU_OUT_WIDTH-1:0] r_res;

  logic                     r_wr_en;
  logic                     r_rd_en;
  logic [ADDR_WIDTH-1:0]    r_rf_addr;
  logic [DATA_WIDTH-1:0]    r_wr_data;
  logic                     r_alu_en;
  logic [FUN_WIDTH-1:0]     r_alu_fun;
  logic                     r_gate_en;
  logic [DATA_WIDTH-1:0]    r_tx_data;
  logic                     r_tx_vld;

  logic [ADDR_WIDTH-1:0]    w_addr;
  logic [ALU_OUT_WIDTH-1:0] w_res;
  logic                     w_wr_en;
  logic                     w_rd_en;
  logic [ADDR_WIDTH-1:0]    w_rf_addr;
  logic [DATA_WIDTH-1:0]    w_wr_data;
  logic                     w_alu_en;
  logic [FUN_WIDTH-1:0]     w_alu_fun;
  logic                     w_gate_en;
  logic [DATA_WIDTH-1:0]    w_tx_data;
  logic                     w_tx_vld;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state decode; bytes arriving in wait/TX states are simply not looked at
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (RX_D_VLD) begin
          if      (RX_P_DATA == DATA_WIDTH'(CMD_RF_WR))   w_next_state = WR_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_RF_RD))   w_next_state = RD_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP))  w_next_state = ALU_A;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) w_next_state = ALU_F;
        end
      end
      WR_ADDR:  if (RX_D_VLD)        w_next_state = WR_DATA;
      WR_DATA:  if (RX_D_VLD)        w_next_state = IDLE;
      RD_ADDR:  if (RX_D_VLD)        w_next_state = RD_WAIT;
      RD_WAIT:  if (RF_RdData_Valid) w_next_state = TX_RD;
      TX_RD:    if (!FIFO_FULL)      w_next_state = IDLE;
      ALU_A:    if (RX_D_VLD)        w_next_state = ALU_B;
      ALU_B:    if (RX_D_VLD)        w_next_state = ALU_F;
      ALU_F:    if (RX_D_VLD)        w_next_state = ALU_WAIT;
      ALU_WAIT: if (ALU_OUT_VLD)     w_next_state = TX_LSB;
      TX_LSB:   if (!FIFO_FULL)      w_next_state = TX_MSB;
      TX_MSB:   if (!FIFO_FULL)      w_next_state = IDLE;
      default:                       w_next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath; buses hold between strobes
  always_comb begin
    w_wr_en   = 1'b0;
    w_rd_en   = 1'b0;
    w_alu_en  = 1'b0;
    w_tx_vld  = 1'b0;
    w_rf_addr = r_rf_addr;
    w_wr_data = r_wr_data;
    w_alu_fun = r_alu_fun;
    w_tx_data = r_tx_data;
    w_addr    = r_addr;
    w_res     = r_res;
    // Gate follows the next state so it lines up with ALU_F/ALU_WAIT exactly
    w_gate_en = (w_next_state == ALU_F) || (w_next_state == ALU_WAIT);
    unique case (r_state)
      WR_ADDR: if (RX_D_VLD) w_addr = RX_P_DATA[ADDR_WIDTH-1:0];
      WR_DATA: begin
        if (RX_D_VLD) begin
          w_wr_en   = 1'b1;
          w_rf_addr = r_addr;
          w_wr_data = RX_P_DATA;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          w_rd_en   = 1'b1;
          w_rf_addr = RX_P_DATA[ADDR_WIDTH-1:0];
        end
      end
      RD_WAIT: if (RF_RdData_Valid) w_res = ALU_OUT_WIDTH'(RF_RdData);
      TX_RD: begin
        if (!FIFO_FULL) begin
          w_tx_vld  = 1'b1;
          w_tx_data = r_res[DATA_WIDTH-1:0];
        end
      end
      ALU_A: begin
        if (RX_D_VLD) begin
          w_wr_en   = 1'b1;
          w_rf_addr = ADDR_WIDTH'(OPA_ADDR);
          w_wr_data = RX_P_DATA;
        end
      end
      ALU_B: begin
        if (RX_D_VLD) begin
          w_wr_en   = 1'b1;
          w_rf_addr = ADDR_WIDTH'(OPB_ADDR);
          w_wr_data = RX_P_DATA;
        end
      end
      ALU_F: begin
        if (RX_D_VLD) begin
          w_alu_en  = 1'b1;
          w_alu_fun = RX_P_DATA[FUN_WIDTH-1:0];
        end
      end
      ALU_WAIT: if (ALU_OUT_VLD) w_res = ALU_OUT;
      TX_LSB: begin
        if (!FIFO_FULL) begin
          w_tx_vld  = 1'b1;
          w_tx_data = r_res[DATA_WIDTH-1:0];
        end
      end
      TX_MSB: begin
        if (!FIFO_FULL) begin
          w_tx_vld  = 1'b1;
          w_tx_data = r_res[ALU_OUT_WIDTH-1:DATA_WIDTH];
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rf_addr <= '0;
      r_wr_data <= '0;
      r_alu_en  <= 1'b0;
      r_alu_fun <= '0;
      r_gate_en <= 1'b0;
      r_tx_data <= '0;
      r_tx_vld  <= 1'b0;
      r_addr    <= '0;
      r_res     <= '0;
    end else begin
      r_wr_en   <= w_wr_en;
      r_rd_en   <= w_rd_en;
      r_rf_addr <= w_rf_addr;
      r_wr_data <= w_wr_data;
      r_alu_en  <= w_alu_en;
      r_alu_fun <= w_alu_fun;
      r_gate_en <= w_gate_en;
      r_tx_data <= w_tx_data;
      r_tx_vld  <= w_tx_vld;
      r_addr    <= w_addr;
      r_res     <= w_res;
    end
  end

  assign RF_WrEn     = r_wr_en;
  assign RF_RdEn     = r_rd_en;
  assign RF_Address  = r_rf_addr;
  assign RF_WrData   = r_wr_data;
  assign ALU_EN      = r_alu_en;
  assign ALU_FUN     = r_alu_fun;
  assign CLK_GATE_EN = r_gate_en;
  assign TX_P_DATA   = r_tx_data;
  assign TX_D_VLD    = r_tx_vld;

endmodule

// File: tb/tb_sys_ctrl_cmd.sv
// Directed bench for sys_ctrl_cmd: write, read, ALU, backpressure and robustness frames.
module tb_sys_ctrl_cmd;

  logic        CLK;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [7:0]  RF_RdData;
  logic        RF_RdData_Valid;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        FIFO_FULL;
  logic        RF_WrEn;
  logic        RF_RdEn;
  logic [3:0]  RF_Address;
  logic [7:0]  RF_WrData;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic        CLK_GATE_EN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int alu_cnt = 0;
  int tx_cnt = 0;
  int both_cnt = 0;

  sys_ctrl_cmd dut (
    .CLK             (CLK),
    .RST             (RST),
    .RX_P_DATA       (RX_P_DATA),
    .RX_D_VLD        (RX_D_VLD),
    .RF_RdData       (RF_RdData),
    .RF_RdData_Valid (RF_RdData_Valid),
    .ALU_OUT         (ALU_OUT),
    .ALU_OUT_VLD     (ALU_OUT_VLD),
    .FIFO_FULL       (FIFO_FULL),
    .RF_WrEn         (RF_WrEn),
    .RF_RdEn         (RF_RdEn),
    .RF_Address      (RF_Address),
    .RF_WrData       (RF_WrData),
    .ALU_EN          (ALU_EN),
    .ALU_FUN         (ALU_FUN),
    .CLK_GATE_EN     (CLK_GATE_EN),
    .TX_P_DATA       (TX_P_DATA),
    .TX_D_VLD        (TX_D_VLD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Strobe tallies, sampled mid-cycle
  always @(negedge CLK) begin
    if (RF_WrEn) wr_cnt++;
    if (RF_RdEn) rd_cnt++;
    if (ALU_EN) alu_cnt++;
    if (TX_D_VLD) tx_cnt++;
    if (RF_WrEn && RF_RdEn) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    step();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wren"},  32'(RF_WrEn), 32'd0);
    chk({tag, "_rden"},  32'(RF_RdEn), 32'd0);
    chk({tag, "_addr"},  32'(RF_Address), 32'd0);
    chk({tag, "_wdata"}, 32'(RF_WrData), 32'd0);
    chk({tag, "_aluen"}, 32'(ALU_EN), 32'd0);
    chk({tag, "_fun"},   32'(ALU_FUN), 32'd0);
    chk({tag, "_gate"},  32'(CLK_GATE_EN), 32'd0);
    chk({tag, "_txd"},   32'(TX_P_DATA), 32'd0);
    chk({tag, "_txv"},   32'(TX_D_VLD), 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    RX_P_DATA = 8'h00;
    RX_D_VLD = 1'b0;
    RF_RdData = 8'h00;
    RF_RdData_Valid = 1'b0;
    ALU_OUT = 16'h0000;
    ALU_OUT_VLD = 1'b0;
    FIFO_FULL = 1'b0;

    // Power-on reset
    #2 RST = 1'b0;
    #3 chk_all_zero("reset");
    #17 RST = 1'b1;
    step();

    // Register write AA,05,3C
    send(8'hAA);
    send(8'h05);
    send(8'h3C);
    chk("wr_en",   32'(RF_WrEn), 32'd1);
    chk("wr_addr", 32'(RF_Address), 32'h5);
    chk("wr_data", 32'(RF_WrData), 32'h3C);
    chk("wr_norden", 32'(RF_RdEn), 32'd0);
    step();
    chk("wr_pulse_end", 32'(RF_WrEn), 32'd0);
    chk("wr_notx", 32'(TX_D_VLD), 32'd0);

    // Register read BB,05 -> data 3C one cycle after RdEn
    send(8'hBB);
    send(8'h05);
    chk("rd_en",   32'(RF_RdEn), 32'd1);
    chk("rd_addr", 32'(RF_Address), 32'h5);
    step();
    chk("rd_pulse_end", 32'(RF_RdEn), 32'd0);
    RF_RdData = 8'h3C;
    RF_RdData_Valid = 1'b1;
    step();
    RF_RdData_Valid = 1'b0;
    chk("rd_tx_early", 32'(TX_D_VLD), 32'd0);
    step();
    chk("rd_txv", 32'(TX_D_VLD), 32'd1);
    chk("rd_txd", 32'(TX_P_DATA), 32'h3C);
    step();
    chk("rd_tx_end", 32'(TX_D_VLD), 32'd0);

    // ALU with operands CC,0A,03,00 -> result 000D
    send(8'hCC);
    chk("aop_gate_a", 32'(CLK_GATE_EN), 32'd0);
    send(8'h0A);
    chk("aop_wa_en",   32'(RF_WrEn), 32'd1);
    chk("aop_wa_addr", 32'(RF_Address), 32'h0);
    chk("aop_wa_data", 32'(RF_WrData), 32'h0A);
    send(8'h03);
    chk("aop_wb_en",   32'(RF_WrEn), 32'd1);
    chk("aop_wb_addr", 32'(RF_Address), 32'h1);
    chk("aop_wb_data", 32'(RF_WrData), 32'h03);
    chk("aop_gate_f",  32'(CLK_GATE_EN), 32'd1);
    send(8'h00);
    chk("aop_en",     32'(ALU_EN), 32'd1);
    chk("aop_fun",    32'(ALU_FUN), 32'h0);
    chk("aop_gate_w", 32'(CLK_GATE_EN), 32'd1);
    chk("aop_nowr",   32'(RF_WrEn), 32'd0);
    step();
    chk("aop_en_end",  32'(ALU_EN), 32'd0);
    chk("aop_gate_w2", 32'(CLK_GATE_EN), 32'd1);
    ALU_OUT = 16'h000D;
    ALU_OUT_VLD = 1'b1;
    step();
    ALU_OUT_VLD = 1'b0;
    chk("aop_gate_off", 32'(CLK_GATE_EN), 32'd0);
    step();
    chk("aop_lsb_v", 32'(TX_D_VLD), 32'd1);
    chk("aop_lsb_d", 32'(TX_P_DATA), 32'h0D);
    step();
    chk("aop_msb_v", 32'(TX_D_VLD), 32'd1);
    chk("aop_msb_d", 32'(TX_P_DATA), 32'h00);
    step();
    chk("aop_tx_end", 32'(TX_D_VLD), 32'd0);

    // ALU without operands DD,02 with 5 full cycles -> 34, 12
    send(8'hDD);
    chk("nop_gate", 32'(CLK_GATE_EN), 32'd1);
    chk("nop_nowr", 32'(RF_WrEn), 32'd0);
    send(8'h02);
    chk("nop_en",  32'(ALU_EN), 32'd1);
    chk("nop_fun", 32'(ALU_FUN), 32'h2);
    ALU_OUT = 16'h1234;
    ALU_OUT_VLD = 1'b1;
    FIFO_FULL = 1'b1;
    step();
    ALU_OUT_VLD = 1'b0;
    chk("bp_hold0", 32'(TX_D_VLD), 32'd0);
    for (int i = 1; i < 5; i++) begin
      step();
      chk("bp_hold", 32'(TX_D_VLD), 32'd0);
    end
    chk("bp_gate", 32'(CLK_GATE_EN), 32'd0);
    FIFO_FULL = 1'b0;
    step();
    chk("bp_lsb_v", 32'(TX_D_VLD), 32'd1);
    chk("bp_lsb_d", 32'(TX_P_DATA), 32'h34);
    step();
    chk("bp_msb_v", 32'(TX_D_VLD), 32'd1);
    chk("bp_msb_d", 32'(TX_P_DATA), 32'h12);
    step();
    chk("bp_end", 32'(TX_D_VLD), 32'd0);

    // Unknown byte 55 leaves every output where it was
    send(8'h55);
    for (int i = 0; i < 2; i++) begin
      chk("unk_wren",  32'(RF_WrEn), 32'd0);
      chk("unk_rden",  32'(RF_RdEn), 32'd0);
      chk("unk_aluen", 32'(ALU_EN), 32'd0);
      chk("unk_gate",  32'(CLK_GATE_EN), 32'd0);
      chk("unk_txv",   32'(TX_D_VLD), 32'd0);
      chk("unk_addr",  32'(RF_Address), 32'h1);
      chk("unk_wdata", 32'(RF_WrData), 32'h03);
      chk("unk_fun",   32'(ALU_FUN), 32'h2);
      chk("unk_txd",   32'(TX_P_DATA), 32'h12);
      step();
    end

    // Reset mid-frame after AA,05
    send(8'hAA);
    send(8'h05);
    #3 RST = 1'b0;
    #1 chk_all_zero("midrst");
    #2 RST = 1'b1;
    step();

    // Fresh write AA,02,FF lands at address 2 only
    send(8'hAA);
    chk("post_nowr0", 32'(RF_WrEn), 32'd0);
    send(8'h02);
    chk("post_nowr1", 32'(RF_WrEn), 32'd0);
    send(8'hFF);
    chk("post_wren",  32'(RF_WrEn), 32'd1);
    chk("post_addr",  32'(RF_Address), 32'h2);
    chk("post_wdata", 32'(RF_WrData), 32'hFF);
    step();
    chk("post_end", 32'(RF_WrEn), 32'd0);
    step();

    // Whole-run strobe totals
    chk("tot_wr",   32'(wr_cnt), 32'd4);
    chk("tot_rd",   32'(rd_cnt), 32'd1);
    chk("tot_alu",  32'(alu_cnt), 32'd2);
    chk("tot_tx",   32'(tx_cnt), 32'd5);
    chk("tot_both", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sys_ctrl_cmd.md
Name: sys_ctrl_cmd

Overview:
- Command decoder/sequencer directly upstream of the register file.
- Consumes byte frames from the UART RX path (already synchronised into the CLK domain).
- Drives the register-file write/read strobes, the ALU enable/function and the clock-gate enable.
- Returns read data and ALU results as bytes to the TX-side async FIFO.

Parameters:
- DATA_WIDTH, 8: RX/TX byte and register-file data width.
- ADDR_WIDTH, 4: register-file address width; the low ADDR_WIDTH bits of the address byte are used.
- ALU_OUT_WIDTH, 16: ALU result width; must equal 2*DATA_WIDTH.
- FUN_WIDTH, 4: ALU function code width.

Ports:
- CLK  in  1  system clock (REF domain).
- RST  in  1  asynchronous, active-low reset.
- RX_P_DATA  in  DATA_WIDTH  received byte.
- RX_D_VLD  in  1  one-cycle pulse; RX_P_DATA is valid this cycle.
- RF_RdData  in  DATA_WIDTH  register-file read data.
- RF_RdData_Valid  in  1  register-file read data valid.
- ALU_OUT  in  ALU_OUT_WIDTH  ALU result.
- ALU_OUT_VLD  in  1  ALU result valid.
- FIFO_FULL  in  1  TX FIFO full.
- RF_WrEn  out  1  register-file write strobe.
- RF_RdEn  out  1  register-file read strobe.
- RF_Address  out  ADDR_WIDTH  register-file address.
- RF_WrData  out  DATA_WIDTH  register-file write data.
- ALU_EN  out  1  ALU enable.
- ALU_FUN  out  FUN_WIDTH  ALU function code.
- CLK_GATE_EN  out  1  ALU clock-gate enable.
- TX_P_DATA  out  DATA_WIDTH  byte pushed to the TX FIFO.
- TX_D_VLD  out  1  TX FIFO write strobe.

Behaviour:
- Reset (RST low, async): all outputs 0; state IDLE; internal address/result registers 0.
- All outputs are registered; every strobe is a single-cycle pulse unless stated otherwise.
- Command bytes are accepted only in IDLE when RX_D_VLD=1:
  - 0xAA: register write.
  - 0xBB: register read.
  - 0xCC: ALU with operands.
  - 0xDD: ALU without operands.
  - Any other byte is ignored; stay in IDLE.
- RX bytes arriving in states that do not expect one (the wait and TX states) are dropped.
- Write (0xAA):
  - IDLE -> WR_ADDR; next RX byte is latched as the address -> WR_DATA.
  - Next RX byte: RF_WrEn=1 for one cycle, with RF_Address=latched address and RF_WrData=byte -> IDLE.
- Read (0xBB):
  - IDLE -> RD_ADDR; on the next RX byte, RF_RdEn=1 and RF_Address=byte for one cycle -> RD_WAIT.
  - RD_WAIT: when RF_RdData_Valid=1, latch RF_RdData -> TX_RD.
  - TX_RD: when FIFO_FULL=0, TX_D_VLD=1 with TX_P_DATA=latched byte -> IDLE. While FIFO_FULL=1, hold with no push.
- ALU with operands (0xCC):
  - ALU_A: next RX byte -> RF_WrEn pulse to address 0.
  - ALU_B: next RX byte -> RF_WrEn pulse to address 1.
  - Then ALU_F.
- ALU without operands (0xDD): go directly to ALU_F.
- ALU_F: CLK_GATE_EN=1; on the next RX byte, ALU_EN=1 for one cycle with ALU_FUN=byte[FUN_WIDTH-1:0] -> ALU_WAIT.
- ALU_WAIT: CLK_GATE_EN held at 1; when ALU_OUT_VLD=1, latch ALU_OUT -> TX_LSB.
- TX_LSB: when FIFO_FULL=0, push ALU_OUT[7:0] -> TX_MSB.
- TX_MSB: when FIFO_FULL=0, push ALU_OUT[15:8] -> IDLE.
- CLK_GATE_EN is 1 only in ALU_F and ALU_WAIT. It is 0 in every other state, including during TX.
- Latency:
  - Write completes on the cycle after the data byte is seen.
  - Read result is pushed on the first non-full cycle after RF_RdData_Valid.
  - Each TX push takes one cycle when the FIFO is not full.
- Never issue RF_WrEn and RF_RdEn in the same cycle.
- No timeout: the block waits indefinitely for missing bytes.
- Reset asserted mid-frame aborts the frame and returns to IDLE with no pending strobe.

Decomposition:
- Shared package sys_ctrl_pkg holds:
  - Command opcodes CMD_RF_WR=8'hAA, CMD_RF_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD.
  - The state enum (IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_RD, ALU_A, ALU_B, ALU_F, ALU_WAIT, TX_LSB, TX_MSB).
  - Fixed operand addresses OPA_ADDR=0, OPB_ADDR=1.
- Single module; no sub-module is needed. The TX byte push may optionally be factored as sys_ctrl_tx_push, but a flat FSM is preferred.

Test Plan:
- Write: RX AA,05,3C -> exactly one RF_WrEn pulse with RF_Address=5, RF_WrData=0x3C; no TX_D_VLD.
- Read: RX BB,05; model returns 0x3C one cycle after RF_RdEn -> one RF_RdEn pulse with Address=5, then TX_D_VLD with TX_P_DATA=0x3C.
- ALU with operands: RX CC,0A,03,00; model returns ALU_OUT=0x000D:
  - RF writes (0,0x0A) then (1,0x03).
  - ALU_EN pulse with ALU_FUN=0.
  - CLK_GATE_EN high from ALU_F until the result is latched.
  - TX pushes 0x0D then 0x00.
- Backpressure: DD,02 with FIFO_FULL=1 for 5 cycles after ALU_OUT_VLD (ALU_OUT=0x1234) -> no push while full, then 0x34, 0x12 on consecutive cycles.
- Robustness:
  - Unknown byte 0x55 in IDLE -> no outputs toggle.
  - RST low mid-frame (after AA,05) -> all outputs 0.
  - Next AA,02,FF writes 0xFF to address 2 only.
